// File: rtl/paddle_locate.sv
// Recovers the paddle rectangle (centre/size) from one frame of a per-pixel hit mask
// by tracking the bounding box of hit pixels, then publishing it once per frame.
module paddle_locate #(
    parameter int COORD_W   = 13,
    parameter int CNT_W     = 20,
    parameter int MIN_COUNT = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pix_valid,
    input  logic [COORD_W-1:0] row,
    input  logic [COORD_W-1:0] col,
    input  logic               hit,
    input  logic               sof,
    input  logic               eof,
    output logic [COORD_W-1:0] crow,
    output logic [COORD_W-1:0] ccol,
    output logic [COORD_W-1:0] height,
    output logic [COORD_W-1:0] width,
    output logic               found,
    output logic               done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_CALC = 2'd2;

    localparam logic [COORD_W-1:0] COORD_ONES = '1;
    localparam logic [CNT_W-1:0]   CNT_MAX    = '1;
    localparam logic [CNT_W-1:0]   MIN_CNT    = CNT_W'(MIN_COUNT);
    localparam logic [COORD_W-1:0] ONE        = COORD_W'(1);

    logic [1:0]         state;
    logic [COORD_W-1:0] rmin, rmax, cmin, cmax;
    logic [CNT_W-1:0]   count;

    logic               start;
    logic               acc_en;
    logic [COORD_W-1:0] base_rmin, base_rmax, base_cmin, base_cmax;
    logic [CNT_W-1:0]   base_count;
    logic [COORD_W-1:0] nxt_rmin, nxt_rmax, nxt_cmin, nxt_cmax;
    logic [CNT_W-1:0]   nxt_count;
    logic [COORD_W-1:0] calc_w, calc_h;

    // A sof in IDLE or SCAN (re)starts a frame; the sof pixel itself is accumulated.
    assign start  = pix_valid && sof && (state != S_CALC);
    assign acc_en = pix_valid && hit && (start || (state == S_SCAN));

    always_comb begin
        base_rmin  = start ? COORD_ONES : rmin;
        base_rmax  = start ? '0 : rmax;
        base_cmin  = start ? COORD_ONES : cmin;
        base_cmax  = start ? '0 : cmax;
        base_count = start ? '0 : count;

        // NOTE: every output of this block gets a default first, so no latch is inferred.
        nxt_rmin  = base_rmin;
        nxt_rmax  = base_rmax;
        nxt_cmin  = base_cmin;
        nxt_cmax  = base_cmax;
        nxt_count = base_count;
        if (acc_en) begin
            if (row < base_rmin) nxt_rmin = row;
            if (row > base_rmax) nxt_rmax = row;
            if (col < base_cmin) nxt_cmin = col;
            if (col > base_cmax) nxt_cmax = col;
            if (base_count != CNT_MAX) nxt_count = base_count + 1'b1;
        end
    end

    // Centre uses the same edge convention as the rasterizer: centre - (size>>1) is the low edge.
    assign calc_w = cmax - cmin + ONE;
    assign calc_h = rmax - rmin + ONE;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            rmin   <= COORD_ONES;
            rmax   <= '0;
            cmin   <= COORD_ONES;
            cmax   <= '0;
            count  <= '0;
            crow   <= '0;
            ccol   <= '0;
            height <= '0;
            width  <= '0;
            found  <= 1'b0;
            done   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register
            // samples the pre-edge values regardless of statement order.
            rmin  <= nxt_rmin;
            rmax  <= nxt_rmax;
            cmin  <= nxt_cmin;
            cmax  <= nxt_cmax;
            count <= nxt_count;
            done  <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (start) state <= eof ? S_CALC : S_SCAN;
                end
                S_SCAN: begin
                    if (pix_valid && eof) state <= S_CALC;
                end
                S_CALC: begin
                    state <= S_IDLE;
                    done  <= 1'b1;
                    if (count >= MIN_CNT) begin
                        width  <= calc_w;
                        height <= calc_h;
                        ccol   <= cmin + (calc_w >> 1);
                        crow   <= rmin + (calc_h >> 1);
                        found  <= 1'b1;
                    end else begin
                        found  <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_paddle_locate.sv
// Scoreboard bench for paddle_locate: two instances (MIN_COUNT 16 and 15) share one
// randomized pixel stream; a hit-list model predicts each frame result and its timing.
module tb_paddle_locate;

    localparam int CW = 13;

    logic          clk = 1'b0;
    logic          reset, pix_valid, hit, sof, eof;
    logic [CW-1:0] row, col;
    logic [CW-1:0] crow0, ccol0, height0, width0, crow1, ccol1, height1, width1;
    logic          found0, done0, found1, done1;

    paddle_locate #(.COORD_W(CW), .CNT_W(20), .MIN_COUNT(16)) dut16 (
        .clk(clk), .reset(reset), .pix_valid(pix_valid), .row(row), .col(col),
        .hit(hit), .sof(sof), .eof(eof), .crow(crow0), .ccol(ccol0),
        .height(height0), .width(width0), .found(found0), .done(done0)
    );

    paddle_locate #(.COORD_W(CW), .CNT_W(20), .MIN_COUNT(15)) dut15 (
        .clk(clk), .reset(reset), .pix_valid(pix_valid), .row(row), .col(col),
        .hit(hit), .sof(sof), .eof(eof), .crow(crow1), .ccol(ccol1),
        .height(height1), .width(width1), .found(found1), .done(done1)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int crow, ccol, h, w;
        int found;
        int rmin, rmax, cmin, cmax;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   min_cnt[2] = '{16, 15};
    int   prev_crow[2], prev_ccol[2], prev_h[2], prev_w[2];

    int   hr[$];
    int   hc[$];
    bit   in_frame = 0;
    int   gap_pct  = 10;

    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(string name, int act, int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Frame result straight from the list of hit coordinates.
    task automatic resolve_frame();
        for (int d = 0; d < 2; d++) begin
            exp_t x;
            x.cyc = cyc + 2;
            x.rmin = 0; x.rmax = 0; x.cmin = 0; x.cmax = 0;
            if (hr.size() >= min_cnt[d]) begin
                x.rmin = hr[0]; x.rmax = hr[0]; x.cmin = hc[0]; x.cmax = hc[0];
                foreach (hr[i]) begin
                    if (hr[i] < x.rmin) x.rmin = hr[i];
                    if (hr[i] > x.rmax) x.rmax = hr[i];
                    if (hc[i] < x.cmin) x.cmin = hc[i];
                    if (hc[i] > x.cmax) x.cmax = hc[i];
                end
                prev_w[d]    = x.cmax - x.cmin + 1;
                prev_h[d]    = x.rmax - x.rmin + 1;
                prev_ccol[d] = x.cmin + prev_w[d] / 2;
                prev_crow[d] = x.rmin + prev_h[d] / 2;
                x.found = 1;
            end else begin
                x.found = 0;
            end
            x.crow = prev_crow[d]; x.ccol = prev_ccol[d];
            x.h    = prev_h[d];    x.w    = prev_w[d];
            if (d == 0) q0.push_back(x); else q1.push_back(x);
        end
    endtask

    task automatic model_pixel(bit s, bit e, bit h, int r, int c);
        if (s) begin
            hr.delete();
            hc.delete();
            in_frame = 1;
        end
        if (in_frame && h) begin
            hr.push_back(r);
            hc.push_back(c);
        end
        if (in_frame && e) begin
            resolve_frame();
            in_frame = 0;
        end
    endtask

    // Invalid cycle carrying junk on every qualified input.
    task automatic junk_cycle();
        @(posedge clk); #1;
        pix_valid = 1'b0;
        hit = 1'($urandom); sof = 1'($urandom); eof = 1'($urandom);
        row = CW'($urandom); col = CW'($urandom);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) junk_cycle();
    endtask

    task automatic pix(bit s, bit e, bit h, int r, int c);
        while ($urandom_range(0, 99) < gap_pct) junk_cycle();
        @(posedge clk); #1;
        pix_valid = 1'b1;
        sof = s; eof = e; hit = h;
        row = CW'(r); col = CW'(c);
        model_pixel(s, e, h, r, c);
    endtask

    task automatic send_frame(int r0, int r1, int c0, int c1,
                              int hr0, int hr1, int hc0, int hc1,
                              int noise_pct, bit with_sof, bit with_eof);
        for (int r = r0; r <= r1; r++) begin
            for (int c = c0; c <= c1; c++) begin
                bit h;
                h = (r >= hr0 && r <= hr1 && c >= hc0 && c <= hc1) ||
                    ($urandom_range(0, 99) < noise_pct);
                pix(with_sof && r == r0 && c == c0, with_eof && r == r1 && c == c1, h, r, c);
            end
        end
        if (with_eof) idle(2);
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        reset = 1'b1; pix_valid = 1'b0;
        hr.delete(); hc.delete(); in_frame = 0;
        for (int d = 0; d < 2; d++) begin
            prev_crow[d] = 0; prev_ccol[d] = 0; prev_h[d] = 0; prev_w[d] = 0;
        end
        idle(2);
        reset = 1'b1;
        check("rst_crow", int'(crow0), 0);
        check("rst_ccol", int'(ccol0), 0);
        check("rst_height", int'(height0), 0);
        check("rst_width", int'(width0), 0);
        check("rst_found", int'(found0), 0);
        check("rst_done", int'(done0), 0);
        check("rst_found15", int'(found1), 0);
        check("rst_width15", int'(width1), 0);
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic score(int d, logic dn, logic f, logic [CW-1:0] cr, logic [CW-1:0] cc,
                         logic [CW-1:0] h, logic [CW-1:0] w);
        exp_t x;
        int   qs;
        string tag;
        tag = (d == 0) ? "m16" : "m15";
        qs  = (d == 0) ? q0.size() : q1.size();
        if (qs > 0) begin
            x = (d == 0) ? q0[0] : q1[0];
            if (!dn && cyc > x.cyc) begin
                check({tag, "_done_missing"}, 0, 1);
                if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
                return;
            end
        end
        if (!dn) return;
        if (qs == 0) begin
            check({tag, "_unexpected_done"}, 1, 0);
            return;
        end
        if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        check({tag, "_done_cycle"}, cyc, x.cyc);
        check({tag, "_found"}, int'(f), x.found);
        check({tag, "_crow"}, int'(cr), x.crow);
        check({tag, "_ccol"}, int'(cc), x.ccol);
        check({tag, "_height"}, int'(h), x.h);
        check({tag, "_width"}, int'(w), x.w);
        if (x.found == 1) begin
            check({tag, "_cmin_recon"}, int'(cc) - int'(w >> 1), x.cmin);
            check({tag, "_cmax_recon"}, int'(cc) + int'((w - 1'b1) >> 1), x.cmax);
            check({tag, "_rmin_recon"}, int'(cr) - int'(h >> 1), x.rmin);
            check({tag, "_rmax_recon"}, int'(cr) + int'((h - 1'b1) >> 1), x.rmax);
        end
    endtask

    always @(negedge clk) begin
        if (reset === 1'b0) begin
            score(0, done0, found0, crow0, ccol0, height0, width0);
            score(1, done1, found1, crow1, ccol1, height1, width1);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; pix_valid = 1'b0; hit = 1'b0; sof = 1'b0; eof = 1'b0;
        row = '0; col = '0;
        apply_reset();

        // Paddle 64x10 at rows 400..409, cols 100..163.
        send_frame(398, 411, 96, 167, 400, 409, 100, 163, 0, 1, 1);
        // Odd size, 15 hits: only the MIN_COUNT=15 instance detects it.
        send_frame(8, 14, 18, 26, 10, 12, 20, 24, 0, 1, 1);
        // 15-hit frame filling its whole window; sof pixel is itself a hit.
        send_frame(0, 2, 0, 4, 0, 2, 0, 4, 0, 1, 1);
        // Stale hits at (0,0), then a restart mid-frame with the clean paddle frame.
        send_frame(0, 1, 0, 3, 0, 0, 0, 0, 0, 1, 0);
        send_frame(398, 411, 96, 167, 400, 409, 100, 163, 0, 1, 1);
        // Dense invalid cycles carrying hit/eof/sof junk.
        gap_pct = 60;
        send_frame(50, 58, 30, 45, 52, 56, 33, 43, 0, 1, 1);
        gap_pct = 10;
        // Single-pixel frame: sof and eof together.
        pix(1, 1, 1, 7, 9);
        idle(2);
        // Reset during SCAN, then an eof with no preceding sof.
        send_frame(100, 105, 100, 120, 101, 104, 102, 118, 0, 1, 0);
        apply_reset();
        send_frame(100, 103, 100, 120, 100, 103, 100, 120, 0, 0, 1);
        idle(3);
        send_frame(200, 215, 300, 330, 203, 212, 305, 322, 0, 1, 1);

        for (int k = 0; k < 20; k++) begin
            int r0, c0, hh, ww, a, b;
            r0 = $urandom_range(0, 8000);
            c0 = $urandom_range(0, 8000);
            hh = $urandom_range(2, 14);
            ww = $urandom_range(2, 18);
            a  = $urandom_range(0, 3);
            b  = $urandom_range(0, 3);
            send_frame(r0, r0 + hh + 5, c0, c0 + ww + 5, r0 + a, r0 + a + hh - 1,
                       c0 + b, c0 + b + ww - 1, 3, 1, 1);
        end

        idle(6);
        while (q0.size() > 0) begin
            void'(q0.pop_front());
            check("m16_done_never_seen", 0, 1);
        end
        while (q1.size() > 0) begin
            void'(q1.pop_front());
            check("m15_done_never_seen", 0, 1);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
